// File: rtl/rm_wb_copier_if.sv
// Wishbone pipelined bus bundle shared by the copier's master and slave ports.
// AdrW sets the word-address width so one definition serves both sides.
interface rm_wb_copier_if #(
  parameter int unsigned AdrW = 28
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AdrW-1:0] adr;
  logic [31:0]     dat_w;
  logic [31:0]     dat_r;
  logic [3:0]      sel;
  logic            ack;
  logic            stall;
  logic            err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, stall, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, stall, err
  );
endinterface

// File: rtl/rm_wb_copier.sv
// Block copier for the RM0 socket: reads LEN words from SRC and writes them to DST over the
// Wishbone master port, one read then one write per word; programmed through the slave port.
module rm_wb_copier #(
  parameter int unsigned LEN_W = 16
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  rm_wb_copier_if.master        wbm,
  rm_wb_copier_if.slave         wbs,
  input  logic [31:0]           irq_in,
  output logic                  irq_out
);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StDone
  } state_e;

  state_e           state_q;
  logic             busy_q, done_q, err_q, ie_q;
  logic [31:0]      src_q, dst_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [27:0]      rd_ptr_q, wr_ptr_q;

  logic             cyc_q, stb_q, we_q;
  logic [3:0]       sel_q;
  logic [27:0]      adr_q;
  logic [31:0]      dat_q;

  logic             ack_q;
  logic [31:0]      rdata_q, rd_mux;

  logic             req, wr_en, start;
  logic [2:0]       idx;
  logic             unused_bits;

  assign req   = wbs.cyc & wbs.stb;
  assign wr_en = req & wbs.we;
  assign idx   = wbs.adr[2:0];
  assign start = wr_en && (idx == 3'd0) && wbs.dat_w[0] && (state_q == StIdle);

  assign unused_bits = ^{irq_in, wbs.sel, wbs.adr[19:3]};

  always_comb begin
    rd_mux = '0;
    case (idx)
      3'd0:    rd_mux = {30'b0, ie_q, 1'b0};
      3'd1:    rd_mux = {29'b0, err_q, done_q, busy_q};
      3'd2:    rd_mux = src_q;
      3'd3:    rd_mux = dst_q;
      3'd4:    rd_mux = 32'(len_q);
      3'd5:    rd_mux = 32'(cnt_q);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ie_q     <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ack_q <= req;
      if (req && !wbs.we) rdata_q <= rd_mux;

      // Register writes come first so hardware updates below take priority.
      if (wr_en) begin
        case (idx)
          3'd0: ie_q <= wbs.dat_w[1];
          3'd1: begin
            if (wbs.dat_w[1]) done_q <= 1'b0;
            if (wbs.dat_w[2]) err_q <= 1'b0;
          end
          3'd2: if (!busy_q) src_q <= wbs.dat_w;
          3'd3: if (!busy_q) dst_q <= wbs.dat_w;
          3'd4: if (!busy_q) len_q <= wbs.dat_w[LEN_W-1:0];
          default: ;
        endcase
      end

      if (cyc_q && wbm.err) begin
        // Bus error aborts the transfer; REMAIN keeps the count at the failing word.
        err_q   <= 1'b1;
        cyc_q   <= 1'b0;
        stb_q   <= 1'b0;
        we_q    <= 1'b0;
        sel_q   <= '0;
        state_q <= StDone;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              done_q   <= 1'b0;
              err_q    <= 1'b0;
              busy_q   <= 1'b1;
              rd_ptr_q <= src_q[29:2];
              wr_ptr_q <= dst_q[29:2];
              cnt_q    <= len_q;
              if (len_q == '0) begin
                state_q <= StDone;
              end else begin
                state_q <= StRdReq;
                cyc_q   <= 1'b1;
                stb_q   <= 1'b1;
                we_q    <= 1'b0;
                sel_q   <= 4'hF;
                adr_q   <= src_q[29:2];
              end
            end
          end
          StRdReq: begin
            if (!wbm.stall) begin
              stb_q   <= 1'b0;
              state_q <= StRdWait;
            end
          end
          StRdWait: begin
            if (wbm.ack) begin
              dat_q    <= wbm.dat_r;
              rd_ptr_q <= rd_ptr_q + 28'd1;
              stb_q    <= 1'b1;
              we_q     <= 1'b1;
              adr_q    <= wr_ptr_q;
              state_q  <= StWrReq;
            end
          end
          StWrReq: begin
            if (!wbm.stall) begin
              stb_q   <= 1'b0;
              state_q <= StWrWait;
            end
          end
          StWrWait: begin
            if (wbm.ack) begin
              wr_ptr_q <= wr_ptr_q + 28'd1;
              cnt_q    <= cnt_q - 1'b1;
              if (cnt_q == LEN_W'(1)) begin
                cyc_q   <= 1'b0;
                we_q    <= 1'b0;
                sel_q   <= '0;
                state_q <= StDone;
              end else begin
                stb_q   <= 1'b1;
                we_q    <= 1'b0;
                adr_q   <= rd_ptr_q;
                state_q <= StRdReq;
              end
            end
          end
          StDone: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign wbm.cyc   = cyc_q;
  assign wbm.stb   = stb_q;
  assign wbm.we    = we_q;
  assign wbm.sel   = sel_q;
  assign wbm.adr   = adr_q;
  assign wbm.dat_w = dat_q;

  assign wbs.ack   = ack_q;
  assign wbs.dat_r = rdata_q;
  assign wbs.stall = 1'b0;
  assign wbs.err   = 1'b0;

  assign irq_out   = done_q & ie_q;

endmodule

// File: tb/tb_rm_wb_copier.sv
// Bench for rm_wb_copier: register vectors from a table, then copy, zero-length, stall,
// bus-error, busy-lockout and mid-transfer reset sequences against a scoreboarded memory.
module tb_rm_wb_copier;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic irq_out;

  rm_wb_copier_if #(.AdrW(28)) wbm ();
  rm_wb_copier_if #(.AdrW(20)) wbs ();

  rm_wb_copier #(.LEN_W(16)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .wbm     (wbm),
    .wbs     (wbs),
    .irq_in  (32'hFFFF_0000),
    .irq_out (irq_out)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Memory model state (written only by the model process).
  int          acc_cnt    = 0;
  int          cyc_cycles = 0;
  int          order_errs = 0;
  int          stall_seen = 0;
  int          act_n      = 0;
  logic        prev_we    = 1'b1;
  logic [27:0] act_adr [256];
  logic [31:0] act_dat [256];

  // Fault injection knobs (written only by the stimulus process).
  int stall_acc = -1;
  int stall_len = 0;
  int err_acc   = -1;

  typedef struct packed {
    logic [27:0] adr;
    logic [31:0] dat;
  } wr_t;
  wr_t exp_q[$];
  int  act_rd = 0;

  typedef struct packed {
    logic [19:0] adr;
    logic        wr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] pat(input logic [27:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[11:0], a[27:24]};
  endfunction

  logic stall_active;
  always_comb
    stall_active = wbm.cyc && wbm.stb && (acc_cnt + 1 == stall_acc) && (stall_seen < stall_len);
  assign wbm.stall = stall_active;

  // Slave memory: ack (or err) one cycle after an accepted strobe.
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm.ack   <= 1'b0;
      wbm.err   <= 1'b0;
      wbm.dat_r <= '0;
      prev_we   <= 1'b1;
      stall_seen <= 0;
    end else begin
      wbm.ack <= 1'b0;
      wbm.err <= 1'b0;
      if (wbm.cyc) cyc_cycles <= cyc_cycles + 1;
      if (stall_active) begin
        stall_seen <= stall_seen + 1;
      end else if (wbm.cyc && wbm.stb) begin
        stall_seen <= 0;
        acc_cnt    <= acc_cnt + 1;
        if (wbm.we == prev_we) order_errs <= order_errs + 1;
        prev_we <= wbm.we;
        if (acc_cnt + 1 == err_acc) begin
          wbm.err <= 1'b1;
        end else begin
          wbm.ack <= 1'b1;
          if (wbm.we) begin
            if (act_n < 256) begin
              act_adr[act_n] <= wbm.adr;
              act_dat[act_n] <= wbm.dat_w;
            end
            act_n <= act_n + 1;
          end else begin
            wbm.dat_r <= pat(wbm.adr);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic reg_wr(input logic [19:0] adr, input logic [31:0] d);
    @(negedge sys_clk);
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b1; wbs.adr = adr; wbs.dat_w = d;
    wbs.sel = 4'hF;
    @(negedge sys_clk);
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
  endtask

  task automatic reg_rd(input logic [19:0] adr, output logic [31:0] d);
    @(negedge sys_clk);
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b0; wbs.adr = adr; wbs.sel = 4'hF;
    @(negedge sys_clk);
    wbs.cyc = 1'b0; wbs.stb = 1'b0;
    check("rd_ack", {31'b0, wbs.ack}, 32'd1);
    d = wbs.dat_r;
  endtask

  task automatic rd_check(input string name, input logic [19:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    reg_rd(adr, d);
    check(name, d, exp);
  endtask

  task automatic wait_done(input string name);
    logic [31:0] s;
    int n;
    s = 32'h1;
    n = 0;
    while (s[0] && n < 200) begin
      reg_rd(20'd1, s);
      n++;
    end
    check({name, "_busy_clear"}, {31'b0, s[0]}, 32'd0);
  endtask

  task automatic compare_writes(input string name);
    while (exp_q.size() != 0) begin
      wr_t e = exp_q.pop_front();
      if (act_rd < act_n) begin
        check({name, "_wr_adr"}, {4'b0, act_adr[act_rd]}, {4'b0, e.adr});
        check({name, "_wr_dat"}, act_dat[act_rd], e.dat);
        act_rd++;
      end else begin
        check({name, "_wr_missing"}, 32'd0, 32'd1);
      end
    end
    check({name, "_wr_extra"}, 32'(act_n - act_rd), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    int base, cyc0, n, bad;

    vecs[0]  = '{adr: 20'd0, wr: 1'b0, wdat: 32'h0,         exp: 32'h0};
    vecs[1]  = '{adr: 20'd1, wr: 1'b0, wdat: 32'h0,         exp: 32'h0};
    vecs[2]  = '{adr: 20'd5, wr: 1'b0, wdat: 32'h0,         exp: 32'h0};
    vecs[3]  = '{adr: 20'd2, wr: 1'b1, wdat: 32'h0000_1003, exp: 32'h0000_1003};
    vecs[4]  = '{adr: 20'd3, wr: 1'b1, wdat: 32'hFFFF_FFFC, exp: 32'hFFFF_FFFC};
    vecs[5]  = '{adr: 20'd4, wr: 1'b1, wdat: 32'hABCD_1234, exp: 32'h0000_1234};
    vecs[6]  = '{adr: 20'd6, wr: 1'b1, wdat: 32'h0000_1234, exp: 32'h0};
    vecs[7]  = '{adr: 20'd7, wr: 1'b1, wdat: 32'hFFFF_FFFF, exp: 32'h0};
    vecs[8]  = '{adr: 20'd0, wr: 1'b1, wdat: 32'h0000_0002, exp: 32'h0000_0002};
    vecs[9]  = '{adr: 20'd1, wr: 1'b1, wdat: 32'h0000_0007, exp: 32'h0};
    vecs[10] = '{adr: 20'd5, wr: 1'b1, wdat: 32'h0000_0055, exp: 32'h0};
    vecs[11] = '{adr: 20'hA, wr: 1'b1, wdat: 32'h0000_0ABC, exp: 32'h0000_0ABC};
    vecs[12] = '{adr: 20'd0, wr: 1'b1, wdat: 32'h0,         exp: 32'h0};

    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0; wbs.adr = '0; wbs.dat_w = '0; wbs.sel = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_ctl", {25'b0, wbm.cyc, wbm.stb, wbm.we, wbm.sel, wbs.ack}, 32'd0);
    check("rst_adr", {4'b0, wbm.adr}, 32'd0);
    check("rst_dat", wbm.dat_w, 32'd0);
    check("rst_irq", {31'b0, irq_out}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) reg_wr(vecs[i].adr, vecs[i].wdat);
      rd_check($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
    end

    // Basic 4-word copy with interrupt enabled.
    reg_wr(20'd2, 32'h0000_1000);
    reg_wr(20'd3, 32'h0000_2000);
    reg_wr(20'd4, 32'd4);
    base = acc_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back({28'h800 + 28'(i), pat(28'h400 + 28'(i))});
    reg_wr(20'd0, 32'h3);
    wait_done("t1");
    check("t1_irq", {31'b0, irq_out}, 32'd1);
    check("t1_cyc_idle", {31'b0, wbm.cyc}, 32'd0);
    rd_check("t1_status", 20'd1, 32'h2);
    rd_check("t1_remain", 20'd5, 32'h0);
    rd_check("t1_ctrl_start_reads_0", 20'd0, 32'h2);
    compare_writes("t1");
    check("t1_accesses", 32'(acc_cnt - base), 32'd8);
    check("t1_order", 32'(order_errs), 32'd0);

    // W1C of done, then zero-length start never touches the bus.
    reg_wr(20'd1, 32'h6);
    rd_check("t2_w1c", 20'd1, 32'h0);
    check("t2_irq_low", {31'b0, irq_out}, 32'd0);
    reg_wr(20'd4, 32'd0);
    cyc0 = cyc_cycles;
    reg_wr(20'd0, 32'h3);
    @(negedge sys_clk);
    check("t2_done_2cyc", {31'b0, irq_out}, 32'd1);
    rd_check("t2_status", 20'd1, 32'h2);
    rd_check("t2_remain", 20'd5, 32'h0);
    check("t2_no_cyc", 32'(cyc_cycles - cyc0), 32'd0);

    // Stall on the first read: strobe and address held, single access.
    reg_wr(20'd2, 32'h0000_3000);
    reg_wr(20'd3, 32'h0000_4000);
    reg_wr(20'd4, 32'd1);
    base = acc_cnt;
    stall_acc = base + 1;
    stall_len = 3;
    exp_q.push_back({28'h1000, pat(28'hC00)});
    reg_wr(20'd0, 32'h3);
    n = 0;
    bad = 0;
    while (wbm.stb && !wbm.we && n < 20) begin
      if (wbm.adr !== 28'hC00) bad++;
      n++;
      @(negedge sys_clk);
    end
    check("t3_stb_hold", 32'(n), 32'd4);
    check("t3_adr_stable", 32'(bad), 32'd0);
    wait_done("t3");
    compare_writes("t3");
    check("t3_accesses", 32'(acc_cnt - base), 32'd2);
    stall_len = 0;

    // Bus error on the second write of a 5-word copy.
    reg_wr(20'd2, 32'h0000_5000);
    reg_wr(20'd3, 32'h0000_6000);
    reg_wr(20'd4, 32'd5);
    base = acc_cnt;
    err_acc = base + 4;
    exp_q.push_back({28'h1800, pat(28'h1400)});
    reg_wr(20'd0, 32'h3);
    n = 0;
    while (!wbm.err && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("t4_err_seen", {31'b0, wbm.err}, 32'd1);
    @(negedge sys_clk);
    check("t4_cyc_drop", {30'b0, wbm.cyc, wbm.stb}, 32'd0);
    wait_done("t4");
    rd_check("t4_status", 20'd1, 32'h6);
    rd_check("t4_remain", 20'd5, 32'd4);
    compare_writes("t4");
    check("t4_accesses", 32'(acc_cnt - base), 32'd4);
    err_acc = -1;

    // Start and register writes while busy are ignored.
    reg_wr(20'd1, 32'h6);
    reg_wr(20'd2, 32'h0000_7000);
    reg_wr(20'd3, 32'h0000_8000);
    reg_wr(20'd4, 32'd3);
    base = acc_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back({28'h2000 + 28'(i), pat(28'h1C00 + 28'(i))});
    reg_wr(20'd0, 32'h3);
    reg_wr(20'd4, 32'd9);
    reg_wr(20'd0, 32'h3);
    reg_wr(20'd2, 32'h0000_9000);
    wait_done("t5");
    rd_check("t5_len_kept", 20'd4, 32'd3);
    rd_check("t5_src_kept", 20'd2, 32'h0000_7000);
    compare_writes("t5");
    check("t5_accesses", 32'(acc_cnt - base), 32'd6);
    check("t5_order", 32'(order_errs), 32'd0);

    // Reset asserted while waiting for a write ack.
    reg_wr(20'd2, 32'h0000_A000);
    reg_wr(20'd3, 32'h0000_B000);
    reg_wr(20'd4, 32'd2);
    reg_wr(20'd0, 32'h3);
    n = 0;
    while (!(wbm.cyc && wbm.we && !wbm.stb) && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("t6_reach_wr_wait", {31'b0, wbm.cyc}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_drop", {29'b0, wbm.cyc, wbm.stb, irq_out}, 32'd0);
    check("t6_sel_adr", {wbm.sel, wbm.adr}, 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    exp_q.delete();
    act_rd = act_n;
    for (int i = 0; i < 8; i++) rd_check($sformatf("t6_reg%0d_zero", i), 20'(i), 32'h0);
    check("t6_cyc_idle", {31'b0, wbm.cyc}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
